// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequential +4 advance, EXE redirects, trap redirects, misaligned-target exceptions.
// Every output is registered. A redirect costs one flush bubble. pc_out holds while fetch_ready is low.
module fetch_pc_gen #(
    parameter int               PC_SZ        = 32,
    parameter logic [PC_SZ-1:0] RESET_VECTOR = '0
) (
    input  logic             clk_in,
    input  logic             reset_n_in,
    input  logic             exe_redirect_valid,
    input  logic [PC_SZ-1:0] exe_br_pc,
    input  logic             exe_mis,
    input  logic             trap_valid,
    input  logic [PC_SZ-1:0] trap_pc,
    input  logic             fetch_ready,
    output logic             pc_valid,
    output logic [PC_SZ-1:0] pc_out,
    output logic             flush_out,
    output logic             mis_exc_valid,
    output logic [PC_SZ-1:0] mis_exc_addr,
    output logic [15:0]      redirect_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, REDIR, EXC} state_t;

    state_t           r_state;
    logic             r_boot_wait;
    logic             r_pc_valid;
    logic [PC_SZ-1:0] r_pc;
    logic             r_flush;
    logic             r_mis_vld;
    logic [PC_SZ-1:0] r_mis_addr;
    logic [15:0]      r_cnt;

    logic [PC_SZ-1:0] w_trap_tgt;
    logic [15:0]      w_cnt_next;
    logic             w_unused;

    // Trap vectors are word-aligned; the low bits of trap_pc are discarded.
    assign w_trap_tgt = {trap_pc[PC_SZ-1:2], 2'b00};
    assign w_cnt_next = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_unused   = ^trap_pc[1:0];

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state     <= BOOT;
            r_boot_wait <= 1'b1;
            r_pc_valid  <= 1'b0;
            r_pc        <= RESET_VECTOR;
            r_flush     <= 1'b0;
            r_mis_vld   <= 1'b0;
            r_mis_addr  <= '0;
            r_cnt       <= '0;
        end else begin
            r_flush <= 1'b0;
            case (r_state)
                BOOT: begin
                    // One full idle cycle so the first request lands on the second edge.
                    if (r_boot_wait) begin
                        r_boot_wait <= 1'b0;
                    end else begin
                        r_state    <= RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (trap_valid) begin
                        r_pc       <= w_trap_tgt;
                        r_state    <= REDIR;
                        r_pc_valid <= 1'b0;
                        r_flush    <= 1'b1;
                        r_cnt      <= w_cnt_next;
                    end else if (exe_redirect_valid && exe_mis) begin
                        r_mis_vld  <= 1'b1;
                        r_mis_addr <= exe_br_pc;
                        r_state    <= EXC;
                        r_pc_valid <= 1'b0;
                        r_flush    <= 1'b1;
                    end else if (exe_redirect_valid) begin
                        r_pc       <= exe_br_pc;
                        r_state    <= REDIR;
                        r_pc_valid <= 1'b0;
                        r_flush    <= 1'b1;
                        r_cnt      <= w_cnt_next;
                    end else if (fetch_ready) begin
                        r_pc <= r_pc + PC_SZ'(4);
                    end
                end
                REDIR: begin
                    if (trap_valid) begin
                        r_pc    <= w_trap_tgt;
                        r_flush <= 1'b1;
                        r_cnt   <= w_cnt_next;
                    end else begin
                        r_state    <= RUN;
                        r_pc_valid <= 1'b1;
                    end
                end
                EXC: begin
                    if (trap_valid) begin
                        r_mis_vld <= 1'b0;
                        r_pc      <= w_trap_tgt;
                        r_state   <= REDIR;
                        r_flush   <= 1'b1;
                        r_cnt     <= w_cnt_next;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    assign pc_valid      = r_pc_valid;
    assign pc_out        = r_pc;
    assign flush_out     = r_flush;
    assign mis_exc_valid = r_mis_vld;
    assign mis_exc_addr  = r_mis_addr;
    assign redirect_cnt  = r_cnt;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen: cycle-by-cycle reference model plus hand-computed spot checks.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exe_redirect_valid = 1'b0;
    logic [31:0] exe_br_pc = '0;
    logic        exe_mis = 1'b0;
    logic        trap_valid = 1'b0;
    logic [31:0] trap_pc = '0;
    logic        fetch_ready = 1'b1;
    logic        pc_valid;
    logic [31:0] pc_out;
    logic        flush_out;
    logic        mis_exc_valid;
    logic [31:0] mis_exc_addr;
    logic [15:0] redirect_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_pc_gen #(.PC_SZ(32), .RESET_VECTOR(32'h0)) dut (
        .clk_in(clk), .reset_n_in(rst_n),
        .exe_redirect_valid(exe_redirect_valid), .exe_br_pc(exe_br_pc), .exe_mis(exe_mis),
        .trap_valid(trap_valid), .trap_pc(trap_pc), .fetch_ready(fetch_ready),
        .pc_valid(pc_valid), .pc_out(pc_out), .flush_out(flush_out),
        .mis_exc_valid(mis_exc_valid), .mis_exc_addr(mis_exc_addr), .redirect_cnt(redirect_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetching / bubble / exception-hold described as flags, not states.
    bit          m_vld, m_flush, m_mis, m_exc_hold;
    int          m_boot_edges;
    logic [31:0] m_pc, m_addr;
    int          m_cnt;

    task automatic m_take(input logic [31:0] tgt);
        m_pc    = tgt;
        m_vld   = 0;
        m_flush = 1;
        if (m_cnt < 65535) m_cnt++;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld = 0; m_flush = 0; m_mis = 0; m_exc_hold = 0;
            m_pc = 32'h0; m_addr = 32'h0; m_cnt = 0; m_boot_edges = 2;
        end else begin
            m_flush = 0;
            if (m_boot_edges > 0) begin
                m_boot_edges--;
                m_vld = (m_boot_edges == 0);
            end else if (trap_valid) begin
                m_take(trap_pc & 32'hFFFF_FFFC);
                m_mis = 0;
                m_exc_hold = 0;
            end else if (m_exc_hold) begin
                m_vld = 0;
            end else if (!m_vld) begin
                m_vld = 1;
            end else if (exe_redirect_valid && exe_mis) begin
                m_mis = 1; m_addr = exe_br_pc; m_flush = 1; m_vld = 0; m_exc_hold = 1;
            end else if (exe_redirect_valid) begin
                m_take(exe_br_pc);
            end else if (fetch_ready) begin
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_valid", {31'd0, pc_valid}, {31'd0, m_vld});
        chk("m_pc", pc_out, m_pc);
        chk("m_flush", {31'd0, flush_out}, {31'd0, m_flush});
        chk("m_mis", {31'd0, mis_exc_valid}, {31'd0, m_mis});
        chk("m_mis_addr", mis_exc_addr, m_addr);
        chk("m_cnt", {16'd0, redirect_cnt}, m_cnt[31:0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] tgt, input logic mis);
        exe_redirect_valid = 1; exe_br_pc = tgt; exe_mis = mis;
        tick();
        exe_redirect_valid = 0; exe_mis = 0;
    endtask

    task automatic release_reset();
        tick();
        rst_n = 1;
        tick();
        tick();
    endtask

    initial begin
        tick();
        tick();
        chk("rst_valid", {31'd0, pc_valid}, 32'd0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_cnt", {16'd0, redirect_cnt}, 32'd0);

        // First request on the second edge after release, then 0,4,8,C.
        rst_n = 1;
        tick();
        chk("boot_edge1_valid", {31'd0, pc_valid}, 32'd0);
        tick();
        chk("boot_edge2_valid", {31'd0, pc_valid}, 32'd1);
        chk("seq_pc0", pc_out, 32'h0);
        tick(); chk("seq_pc4", pc_out, 32'h4);
        tick(); chk("seq_pc8", pc_out, 32'h8);
        tick(); chk("seq_pcC", pc_out, 32'hC);
        chk("seq_noflush", {31'd0, flush_out}, 32'd0);
        repeat (61) tick();
        chk("seq_pc100", pc_out, 32'h100);

        redirect(32'h2000, 0);
        chk("redir_flush", {31'd0, flush_out}, 32'd1);
        chk("redir_bubble", {31'd0, pc_valid}, 32'd0);
        tick();
        chk("redir_valid", {31'd0, pc_valid}, 32'd1);
        chk("redir_pc", pc_out, 32'h2000);
        chk("redir_cnt", {16'd0, redirect_cnt}, 32'd1);

        // Trap outranks a same-cycle EXE redirect.
        trap_valid = 1; trap_pc = 32'h8000_0003;
        redirect(32'h40, 0);
        trap_valid = 0;
        chk("trap_pc_align", pc_out, 32'h8000_0000);
        tick();
        chk("trap_pc_run", pc_out, 32'h8000_0000);
        chk("trap_cnt", {16'd0, redirect_cnt}, 32'd2);

        redirect(32'h1002, 1);
        chk("mis_valid", {31'd0, mis_exc_valid}, 32'd1);
        chk("mis_addr", mis_exc_addr, 32'h1002);
        exe_redirect_valid = 1; exe_br_pc = 32'h5000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mis_hold_valid", {31'd0, mis_exc_valid}, 32'd1);
            chk("mis_hold_addr", mis_exc_addr, 32'h1002);
            chk("mis_hold_nofetch", {31'd0, pc_valid}, 32'd0);
        end
        exe_redirect_valid = 0;
        trap_valid = 1; trap_pc = 32'h300;
        tick();
        trap_valid = 0;
        chk("mis_cleared", {31'd0, mis_exc_valid}, 32'd0);
        tick();
        chk("mis_resume_pc", pc_out, 32'h300);
        chk("mis_resume_valid", {31'd0, pc_valid}, 32'd1);
        chk("mis_cnt", {16'd0, redirect_cnt}, 32'd3);

        fetch_ready = 0;
        redirect(32'h40, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", pc_out, 32'h40);
        end
        redirect(32'hFFFF_FFFC, 0);
        fetch_ready = 1;
        tick();
        chk("wrap_pre", pc_out, 32'hFFFF_FFFC);
        tick();
        chk("wrap_post", pc_out, 32'h0);

        // Async reset in the bubble leaves no flush behind.
        redirect(32'h500, 0);
        #2 rst_n = 0;
        #1;
        chk("rst_redir_flush", {31'd0, flush_out}, 32'd0);
        chk("rst_redir_pc", pc_out, 32'h0);
        release_reset();
        redirect(32'h2, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_exc_mis", {31'd0, mis_exc_valid}, 32'd0);
        chk("rst_exc_addr", mis_exc_addr, 32'h0);
        release_reset();

        // A held trap re-arms the bubble every cycle, counting once per edge.
        trap_valid = 1; trap_pc = 32'h1000;
        repeat (65540) tick();
        trap_valid = 0;
        chk("sat_cnt", {16'd0, redirect_cnt}, 32'hFFFF);
        tick();
        redirect(32'h40, 0);
        chk("sat_hold", {16'd0, redirect_cnt}, 32'hFFFF);
        tick();
        chk("sat_pc", pc_out, 32'h40);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
